// File: rtl/loop_replay_buffer.sv
// Loop replay buffer: captures a backward-branch loop body from the IF/ID stream and
// replays it from local storage, holding fetch off, until the loop-closing branch mispredicts.
module loop_replay_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loop_detect,
    input  logic [31:0]       loop_start_pc,
    input  logic [31:0]       loop_end_pc,
    input  logic              if_valid,
    input  logic [31:0]       curr_PC,
    input  logic [31:0]       instruction,
    input  logic              mispredict,
    input  logic              stall,
    output logic              reuse_signal,
    output logic              replay_valid,
    output logic [31:0]       replay_instr,
    output logic [31:0]       replay_pc,
    output logic [ADDR_W:0]   buf_count,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY} state_t;

    state_t              state;
    logic [31:0]         start_pc;
    logic [31:0]         end_pc;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count;
    logic [31:0]         mem [DEPTH];

    logic [31:0]         span;
    logic [31:0]         len;
    logic                reject;
    logic [31:0]         expected_pc;
    logic                pc_match;
    logic                cap_wr;
    logic                rd_last;

    always_comb begin
        span        = loop_end_pc - loop_start_pc;
        len         = (span >> 2) + 32'd1;
        reject      = (loop_start_pc > loop_end_pc) || (loop_start_pc[1:0] != 2'b00) ||
                      (loop_end_pc[1:0] != 2'b00) || (len > DEPTH);
        expected_pc = start_pc + {{(30-ADDR_W){1'b0}}, wr_ptr, 2'b00};
        pc_match    = (curr_PC == expected_pc);
        cap_wr      = (state == CAPTURE) && !mispredict && if_valid && pc_match;
        rd_last     = ({1'b0, rd_ptr} == (count - (ADDR_W+1)'(1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            start_pc <= '0;
            end_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (mispredict) begin
                state  <= IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (loop_detect) begin
                            if (reject) begin
                                overflow <= 1'b1;
                            end else begin
                                start_pc <= loop_start_pc;
                                end_pc   <= loop_end_pc;
                                wr_ptr   <= '0;
                                state    <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        // A valid PC off the straight-line path means the body is not a clean loop.
                        if (if_valid) begin
                            if (pc_match) begin
                                wr_ptr <= wr_ptr + ADDR_W'(1);
                                if (curr_PC == end_pc) begin
                                    count  <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
                                    rd_ptr <= '0;
                                    state  <= REPLAY;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    REPLAY: begin
                        if (!stall) begin
                            rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_wr) begin
            mem[wr_ptr] <= instruction;
        end
    end

    always_comb begin
        reuse_signal = (state == REPLAY);
        replay_valid = (state == REPLAY);
        replay_instr = '0;
        replay_pc    = '0;
        buf_count    = '0;
        if (state == REPLAY) begin
            replay_instr = mem[rd_ptr];
            replay_pc    = start_pc + {{(30-ADDR_W){1'b0}}, rd_ptr, 2'b00};
            buf_count    = count;
        end
    end

endmodule

// File: tb/tb_loop_replay_buffer.sv
// Randomised bench for loop_replay_buffer against a queue-based model of the loop body.
module tb_loop_replay_buffer;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        loop_detect;
    logic [31:0] loop_start_pc;
    logic [31:0] loop_end_pc;
    logic        if_valid;
    logic [31:0] curr_PC;
    logic [31:0] instruction;
    logic        mispredict;
    logic        stall;
    logic        reuse_signal;
    logic        replay_valid;
    logic [31:0] replay_instr;
    logic [31:0] replay_pc;
    logic [4:0]  buf_count;
    logic        overflow;

    loop_replay_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .loop_detect(loop_detect),
        .loop_start_pc(loop_start_pc), .loop_end_pc(loop_end_pc),
        .if_valid(if_valid), .curr_PC(curr_PC), .instruction(instruction),
        .mispredict(mispredict), .stall(stall),
        .reuse_signal(reuse_signal), .replay_valid(replay_valid),
        .replay_instr(replay_instr), .replay_pc(replay_pc),
        .buf_count(buf_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [71:0] dut_out;
    assign dut_out = {reuse_signal, replay_valid, replay_instr, replay_pc, buf_count, overflow};

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Model: loop body as a queue, replay position as an index into it.
    bit          m_cap, m_rep, m_ovf;
    logic [31:0] m_start, m_end;
    logic [31:0] body[$];
    int unsigned pos;

    function automatic void model_clear();
        m_cap = 0; m_rep = 0; m_ovf = 0; pos = 0;
        body.delete();
    endfunction

    function automatic void model_edge();
        longint unsigned s, e;
        m_ovf = 0;
        if (mispredict) begin
            m_cap = 0; m_rep = 0; body.delete();
        end else if (m_rep) begin
            if (!stall) pos = (pos + 1) % body.size();
        end else if (m_cap) begin
            if (if_valid) begin
                if (curr_PC == m_start + 32'(4 * body.size())) begin
                    body.push_back(instruction);
                    if (curr_PC == m_end) begin
                        m_cap = 0; m_rep = 1; pos = 0;
                    end
                end else begin
                    m_cap = 0; body.delete();
                end
            end
        end else if (loop_detect) begin
            s = longint'(loop_start_pc);
            e = longint'(loop_end_pc);
            if (s > e || s % 4 != 0 || e % 4 != 0 || (e - s) / 4 + 1 > DEPTH) begin
                m_ovf = 1;
            end else begin
                m_cap = 1; m_start = loop_start_pc; m_end = loop_end_pc; body.delete();
            end
        end
    endfunction

    function automatic logic [71:0] model_out();
        if (m_rep)
            return {2'b11, body[pos], m_start + 32'(4 * pos), 5'(body.size()), m_ovf};
        return {2'b00, 64'd0, 5'd0, m_ovf};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_clear(); else model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        loop_detect = 0; if_valid = 0; mispredict = 0; stall = 0;
        curr_PC = '0; instruction = '0; loop_start_pc = '0; loop_end_pc = '0;
    endtask

    // Setup only: detect a loop and feed its body in order.
    task automatic load_loop(input logic [31:0] s, input logic [31:0] e);
        loop_detect = 1; loop_start_pc = s; loop_end_pc = e;
        tick();
        loop_detect = 0;
        for (logic [31:0] pc = s; ; pc += 4) begin
            if_valid = 1; curr_PC = pc; instruction = $urandom;
            tick();
            if (pc == e) break;
        end
        if_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        tick(); tick();
        vectors++;
        if (dut_out !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", dut_out, 72'd0);
        end
        reset = 1;
        tick();
        vectors++;
        if (dut_out !== model_out()) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", dut_out, model_out());
        end
    endtask

    task automatic test_basic_replay();
        loop_detect = 1; loop_start_pc = 32'h0; loop_end_pc = 32'hC;
        tick();
        loop_detect = 0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1; curr_PC = 32'(4 * i); instruction = $urandom;
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL basic_capture[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        for (int i = 0; i < 10; i++) begin
            if_valid = $urandom_range(0, 1); curr_PC = $urandom; instruction = $urandom;
            loop_detect = $urandom_range(0, 1);
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL basic_replay[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin
            stall = (i < 3) ? 1'b1 : (i < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        stall = 0;
    endtask

    task automatic test_mispredict();
        int n = 0;
        while (!(m_rep && m_start + 32'(4 * pos) == 32'h8) && n < 8) begin
            tick(); n++;
        end
        vectors++;
        if (!(m_rep && replay_pc === 32'h8)) begin
            miscompares++;
            $display("FAIL mispredict_reach: got pc %h want %h", replay_pc, 32'h8);
        end
        mispredict = 1;
        tick();
        mispredict = 0;
        vectors++;
        if (dut_out !== model_out() || reuse_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL mispredict_exit: got %h want %h", dut_out, model_out());
        end
        loop_detect = 1; loop_start_pc = 32'h100; loop_end_pc = 32'h108;
        tick();
        loop_detect = 0;
        for (int i = 0; i < 12; i++) begin
            if_valid = (i != 1);
            curr_PC = 32'h100 + 32'(4 * (i < 1 ? i : i - 1));
            instruction = $urandom;
            if (i > 3) if_valid = 0;
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL recapture[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_replay();
        mispredict = 1; tick(); mispredict = 0;
        load_loop(32'h40, 32'h48);
        tick(); tick();
        #2;
        reset = 0;
        #1;
        model_clear();
        vectors++;
        if (dut_out !== 72'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", dut_out, 72'd0);
        end
        @(posedge clk); #1;
        reset = 1;
        tick();
        vectors++;
        if (dut_out !== model_out()) begin
            miscompares++;
            $display("FAIL after_reset_idle: got %h want %h", dut_out, model_out());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] tbl_s[5] = '{32'h0,  32'h20, 32'h2,  32'h0,  32'hFFFF_FFF8};
        logic [31:0] tbl_e[5] = '{32'h40, 32'h0,  32'h10, 32'h12, 32'h4};
        for (int i = 0; i < 5; i++) begin
            loop_detect = 1; loop_start_pc = tbl_s[i]; loop_end_pc = tbl_e[i];
            tick();
            loop_detect = 0;
            vectors++;
            if (dut_out !== model_out() || overflow !== 1'b1) begin
                miscompares++;
                $display("FAIL overflow_pulse[%0d]: got %h want %h", i, dut_out, model_out());
            end
            if_valid = 1; curr_PC = tbl_s[i]; instruction = $urandom;
            tick();
            if_valid = 0;
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL overflow_idle[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        // Mispredict drops a concurrent loop_detect, valid or not.
        for (int i = 0; i < 2; i++) begin
            loop_detect = 1; mispredict = 1;
            loop_start_pc = 32'h0; loop_end_pc = (i == 0) ? 32'h40 : 32'h4;
            tick();
            loop_detect = 0; mispredict = 0;
            if_valid = 1; curr_PC = 32'h0; instruction = $urandom;
            tick();
            if_valid = 1; curr_PC = 32'h4;
            tick();
            if_valid = 0;
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL mispredict_drop[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        // Full-depth and single-instruction loops.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) load_loop(32'h200, 32'h23C); else load_loop(32'h300, 32'h300);
            for (int i = 0; i < 20; i++) begin
                stall = (i % 7 == 3);
                tick();
                vectors++;
                if (dut_out !== model_out()) begin
                    miscompares++;
                    $display("FAIL boundary_len[%0d][%0d]: got %h want %h", k, i, dut_out, model_out());
                end
            end
            stall = 0; mispredict = 1; tick(); mispredict = 0;
        end
    endtask

    task automatic test_abort();
        logic [31:0] seq[5] = '{32'h10, 32'h14, 32'h30, 32'h18, 32'h1C};
        loop_detect = 1; loop_start_pc = 32'h10; loop_end_pc = 32'h1C;
        tick();
        loop_detect = 0;
        for (int i = 0; i < 7; i++) begin
            if_valid = (i < 5); curr_PC = seq[i % 5]; instruction = $urandom;
            tick();
            vectors++;
            if (dut_out !== model_out() || reuse_signal !== 1'b0) begin
                miscompares++;
                $display("FAIL abort[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        loop_detect = 1; loop_start_pc = 32'h10; loop_end_pc = 32'h18;
        tick();
        loop_detect = 0;
        for (int i = 0; i < 5; i++) begin
            mispredict = (i == 2);
            if_valid = 1; curr_PC = 32'h10 + 32'(4 * (i < 2 ? i : i - 1)); instruction = $urandom;
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL capture_flush[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] s, e, t;
        int unsigned r;
        for (int i = 0; i < 600; i++) begin
            loop_detect = ($urandom_range(0, (m_cap || m_rep) ? 19 : 5) == 0);
            r = $urandom_range(0, 9);
            s = (r == 0) ? 32'hFFFF_FFC0 : 32'($urandom_range(0, 63) * 4);
            e = s + 32'($urandom_range(0, 18) * 4);
            if (r == 1) e[0] = 1'b1;
            if (r == 2) begin t = s; s = e; e = t; end
            loop_start_pc = s; loop_end_pc = e;
            if_valid = ($urandom_range(0, 3) != 0);
            curr_PC = (m_cap && $urandom_range(0, 15) != 0) ? m_start + 32'(4 * body.size())
                                                           : 32'($urandom_range(0, 255) * 4);
            instruction = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            mispredict = ($urandom_range(0, 39) == 0);
            tick();
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_out, model_out());
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        test_reset();
        test_basic_replay();
        test_stall();
        test_mispredict();
        test_reset_mid_replay();
        test_overflow();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
